pwm_from_count: RTL and testbench
=================================

Name: pwm_from_count

Overview:
- Consumes the free-running 4-bit count from the mod-16 counter and turns it into a registered, glitch-free PWM output with period 2^WIDTH counts.
- Duty is updated only at the period boundary through a load/ack handshake.
- Supervises the incoming count sequence: any illegal step drops the block into a resync state and flags an error.
- Sits directly downstream of the counter, in the same clk domain.

Parameters:
- WIDTH, 4, width of count_in and duty values; period = 2^WIDTH counts.
- RESET_DUTY, 0, active duty value after reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- count_in  input  WIDTH  count value from the upstream mod-16 counter.
- duty_in  input  WIDTH  requested duty, in counts high per period.
- duty_load  input  1  request to capture duty_in.
- duty_busy  output  1  high while a captured duty is pending; duty_load is ignored while high.
- duty_ack  output  1  one-cycle pulse in the cycle the pending duty becomes active.
- pwm_out  output  1  registered PWM output.
- period_tick  output  1  one-cycle pulse per detected wrap (count_in == 0 in RUN).
- seq_err  output  1  one-cycle pulse on an illegal count step.

Behaviour:
- Reset (async assert, sync release): state=SYNC, prev_cnt=0, active_duty=RESET_DUTY, pending=0.
- Reset values: pwm_out=0, duty_busy=0, duty_ack=0, period_tick=0, seq_err=0.
- prev_cnt <= count_in every cycle, in all states.
- States: SYNC, RUN.
- SYNC:
  - pwm_out=0.
  - Move to RUN when count_in == 0 is sampled. That cycle counts as a wrap: period_tick pulses and the pending duty is applied.
- RUN: legal step is count_in == prev_cnt (hold) or count_in == prev_cnt+1 mod 2^WIDTH (15->0 is legal). Any other value:
  - seq_err pulses next cycle.
  - state goes to SYNC.
  - pwm_out is forced to 0 next cycle.
  - No period_tick, even if count_in == 0; the next sampled 0 in SYNC resyncs.
- Wrap in RUN: count_in == 0 AND prev_cnt == 2^WIDTH-1 produces period_tick. A hold at 0 does not re-tick.
- PWM, in RUN: pwm_out <= (count_in < active_duty_next), one-cycle latency from count_in.
  - active_duty_next is the pending value on a wrap cycle with pending=1, otherwise active_duty.
  - duty=0 gives constant low; duty=2^WIDTH-1 gives high for 15 of 16 counts.
  - Full-on is not representable; that is the intended behaviour.
- Duty handshake:
  - duty_load sampled with pending=0: pend_duty <= duty_in, pending <= 1, so duty_busy is high the next cycle.
  - On the next wrap (or SYNC->RUN entry): active_duty <= pend_duty, pending <= 0, duty_ack pulses.
  - duty_load while pending=1 is ignored; no overwrite.
  - duty_load in the same cycle as a wrap that applies an earlier pending value is ignored. The requester waits for duty_busy low.
  - duty_load with pending=0 in a wrap cycle is captured and applied at the following wrap.
- Reset mid-operation: all state, including pending duty, is discarded immediately; outputs go to reset values asynchronously.
- Comparison is unsigned, WIDTH bits; there are no width extensions beyond the +1 mod 2^WIDTH step check.

Decomposition:
- Shared package:
  - state encoding constants SYNC=1'b0, RUN=1'b1.
  - default WIDTH=4.
- One natural sub-module: pwm_seq_check. It holds prev_cnt, the legal-step check and wrap detection, and outputs step_ok and wrap.
- The top level holds the FSM, duty handshake and PWM compare.

Test Plan:
- Reset then counter stepping 0..15 repeatedly with duty=0:
  - pwm_out stays 0.
  - period_tick pulses at the first sampled 0 and every 16 cycles after.
  - seq_err never fires.
- duty_in=5, duty_load pulse while count=9:
  - duty_busy high next cycle.
  - duty_ack and period_tick coincide at the next count=0.
  - pwm_out high for exactly 5 cycles per period, lagging count_in by 1 cycle.
- Second duty_load (duty_in=12) while busy with duty=3 pending:
  - duty 3 applied, 12 ignored.
  - pwm_out high 3 cycles/period.
  - Then load 12 with busy low: 12 cycles high after the next wrap.
- Inject count jump 6->11 in RUN:
  - seq_err pulse one cycle later.
  - pwm_out 0 until count_in returns to 0.
  - Resync tick at that 0.
  - Normal PWM resumes.
- Counter hold (count stays 7 for 4 cycles) in RUN: no seq_err, pwm_out stable, period extends by 4 cycles.
- Assert rst mid-period with duty=10 active and duty=2 pending:
  - pwm_out=0 immediately.
  - After release the active duty is 0.
  - The pending value is lost; duty_ack does not fire at the next wrap.

Source files
------------

// File: rtl/pwm_from_count_pkg.sv
// Shared types and defaults for the count-driven PWM block.
package pwm_from_count_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Single-cycle status bits plus the PWM level, registered together.
  typedef struct packed {
    logic pwm;
    logic ack;
    logic tick;
    logic err;
  } pwm_flags_t;

endpackage

// File: rtl/pwm_seq_check.sv
// Tracks the previous count and classifies the current count step.
module pwm_seq_check #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count_in,
  output logic             step_ok,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] prev_cnt;
  logic [WIDTH-1:0] prev_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_cnt <= '0;
    else     prev_cnt <= count_in;
  end

  // Increment wraps naturally at WIDTH bits, so 2^WIDTH-1 -> 0 is a legal step.
  assign prev_inc = prev_cnt + WIDTH'(1);
  assign step_ok  = (count_in == prev_cnt) || (count_in == prev_inc);
  assign wrap     = (count_in == '0) && (prev_cnt == CNT_MAX);

endmodule

// File: rtl/pwm_from_count.sv
// PWM generator driven by an upstream free-running counter, with
// boundary-synchronous duty updates and count-sequence supervision.
module pwm_from_count
  import pwm_from_count_pkg::*;
#(
  parameter int unsigned      WIDTH      = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_DUTY = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count_in,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             duty_load,
  output logic             duty_busy,
  output logic             duty_ack,
  output logic             pwm_out,
  output logic             period_tick,
  output logic             seq_err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] active_duty_q, active_duty_d;
  logic [WIDTH-1:0] pend_duty_q, pend_duty_d;
  logic [WIDTH-1:0] duty_next;
  logic             pending_q, pending_d;
  pwm_flags_t       flags_q, flags_d;
  logic             step_ok;
  logic             wrap;
  logic             cnt_zero;
  logic             wrap_evt;
  logic             apply;

  pwm_seq_check #(
    .WIDTH (WIDTH)
  ) u_seq_check (
    .clk      (clk),
    .rst      (rst),
    .count_in (count_in),
    .step_ok  (step_ok),
    .wrap     (wrap)
  );

  assign cnt_zero = (count_in == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= SYNC;
      active_duty_q <= RESET_DUTY;
      pend_duty_q   <= '0;
      pending_q     <= 1'b0;
      flags_q       <= '0;
    end else begin
      state_q       <= state_d;
      active_duty_q <= active_duty_d;
      pend_duty_q   <= pend_duty_d;
      pending_q     <= pending_d;
      flags_q       <= flags_d;
    end
  end

  // Next-state, duty handshake and PWM compare.
  always_comb begin
    state_d       = state_q;
    active_duty_d = active_duty_q;
    pend_duty_d   = pend_duty_q;
    pending_d     = pending_q;
    flags_d       = '0;
    wrap_evt      = 1'b0;
    apply         = 1'b0;
    duty_next     = active_duty_q;

    case (state_q)
      SYNC: begin
        if (cnt_zero) begin
          wrap_evt = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (!step_ok) begin
          flags_d.err = 1'b1;
          state_d     = SYNC;
        end else if (wrap) begin
          wrap_evt = 1'b1;
        end
      end
      default: state_d = SYNC;
    endcase

    apply = wrap_evt && pending_q;
    if (apply) duty_next = pend_duty_q;

    flags_d.tick = wrap_evt;
    flags_d.ack  = apply;
    // Output is low whenever the next state is SYNC, including the error cycle.
    if (state_d == RUN) flags_d.pwm = (count_in < duty_next);

    // A load coinciding with an apply is dropped because pending_q is still set.
    if (apply) begin
      active_duty_d = pend_duty_q;
      pending_d     = 1'b0;
    end else if (duty_load && !pending_q) begin
      pend_duty_d = duty_in;
      pending_d   = 1'b1;
    end
  end

  assign pwm_out     = flags_q.pwm;
  assign duty_ack    = flags_q.ack;
  assign period_tick = flags_q.tick;
  assign seq_err     = flags_q.err;
  assign duty_busy   = pending_q;

endmodule

// File: tb/tb_pwm_from_count.sv
// Self-checking bench for pwm_from_count against a behavioural period model.
module tb_pwm_from_count;

  localparam int M = 16;

  logic       clk;
  logic       rst;
  logic [3:0] count_in;
  logic [3:0] duty_in;
  logic       duty_load;
  logic       duty_busy;
  logic       duty_ack;
  logic       pwm_out;
  logic       period_tick;
  logic       seq_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cnt   = 0;

  // Reference model state
  bit m_run;
  int m_prev, m_act, m_pval;
  bit m_pend;
  bit e_pwm, e_busy, e_ack, e_tick, e_err;

  pwm_from_count #(
    .WIDTH      (4),
    .RESET_DUTY (4'd0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .count_in    (count_in),
    .duty_in     (duty_in),
    .duty_load   (duty_load),
    .duty_busy   (duty_busy),
    .duty_ack    (duty_ack),
    .pwm_out     (pwm_out),
    .period_tick (period_tick),
    .seq_err     (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_run = 0; m_prev = 0; m_act = 0; m_pval = 0; m_pend = 0;
    e_pwm = 0; e_busy = 0; e_ack = 0; e_tick = 0; e_err = 0;
  endtask

  task automatic model(input int c, input int d, input bit l);
    bit wr, bad, nrun;
    int nd;
    wr = 0; bad = 0;
    if (!m_run) wr = (c == 0);
    else if (c != m_prev && c != (m_prev + 1) % M) bad = 1;
    else wr = (c == 0 && m_prev == M - 1);
    nd     = (wr && m_pend) ? m_pval : m_act;
    nrun   = bad ? 1'b0 : (m_run | wr);
    e_err  = bad;
    e_tick = wr;
    e_ack  = wr && m_pend;
    e_pwm  = nrun && (c < nd);
    if (e_ack) begin
      m_act = m_pval; m_pend = 0;
    end else if (l && !m_pend) begin
      m_pval = d; m_pend = 1;
    end
    m_run = nrun; m_prev = c; e_busy = m_pend;
  endtask

  task automatic step(input int c, input int d, input bit l);
    count_in  = 4'(c);
    duty_in   = 4'(d);
    duty_load = l;
    @(posedge clk);
    model(c, d, l);
    cnt = c;
    @(negedge clk);
  endtask

  task automatic run_to(input int target);
    while (cnt != target) step((cnt + 1) % M, 0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; count_in = '0; duty_in = '0; duty_load = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (pwm_out !== 1'b0)     begin n_bad++; $display("FAIL reset_pwm got %b want 0", pwm_out); end
    n_cmp++; if (duty_busy !== 1'b0)   begin n_bad++; $display("FAIL reset_busy got %b want 0", duty_busy); end
    n_cmp++; if (duty_ack !== 1'b0)    begin n_bad++; $display("FAIL reset_ack got %b want 0", duty_ack); end
    n_cmp++; if (period_tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick got %b want 0", period_tick); end
    n_cmp++; if (seq_err !== 1'b0)     begin n_bad++; $display("FAIL reset_err got %b want 0", seq_err); end
    rst = 1'b0;
  endtask

  task automatic test_duty_zero();
    int ticks = 0;
    for (int i = 0; i < 3 * M; i++) begin
      step(i % M, 0, 1'b0);
      ticks += int'(period_tick);
      n_cmp++; if (pwm_out !== 1'b0) begin n_bad++; $display("FAIL zero_pwm i=%0d got %b want 0", i, pwm_out); end
      n_cmp++; if (period_tick !== (i % M == 0)) begin n_bad++; $display("FAIL zero_tick i=%0d got %b want %b", i, period_tick, (i % M == 0)); end
      n_cmp++; if (seq_err !== 1'b0) begin n_bad++; $display("FAIL zero_err i=%0d got %b want 0", i, seq_err); end
    end
    n_cmp++; if (ticks != 3) begin n_bad++; $display("FAIL zero_tick_count got %0d want 3", ticks); end
  endtask

  task automatic test_duty_load5();
    int highs;
    run_to(8);
    step(9, 5, 1'b1);
    n_cmp++; if (duty_busy !== 1'b1) begin n_bad++; $display("FAIL load5_busy got %b want 1", duty_busy); end
    run_to(15);
    step(0, 0, 1'b0);
    n_cmp++; if (duty_ack !== 1'b1 || period_tick !== 1'b1) begin n_bad++; $display("FAIL load5_ack_tick got ack=%b tick=%b want 1/1", duty_ack, period_tick); end
    highs = int'(pwm_out);
    for (int k = 1; k < M; k++) begin
      step(k, 0, 1'b0);
      highs += int'(pwm_out);
      n_cmp++; if (pwm_out !== (k < 5)) begin n_bad++; $display("FAIL load5_pwm k=%0d got %b want %b", k, pwm_out, (k < 5)); end
    end
    n_cmp++; if (highs != 5) begin n_bad++; $display("FAIL load5_highs got %0d want 5", highs); end
    n_cmp++; if (duty_busy !== 1'b0) begin n_bad++; $display("FAIL load5_busy_clear got %b want 0", duty_busy); end
  endtask

  task automatic test_busy_ignore();
    int highs;
    run_to(2);
    step(3, 3, 1'b1);
    step(4, 12, 1'b1);
    n_cmp++; if (duty_busy !== 1'b1) begin n_bad++; $display("FAIL busy_hold got %b want 1", duty_busy); end
    run_to(15);
    step(0, 0, 1'b0);
    n_cmp++; if (duty_ack !== 1'b1) begin n_bad++; $display("FAIL busy_ack3 got %b want 1", duty_ack); end
    highs = int'(pwm_out);
    for (int k = 1; k < M; k++) begin
      step(k, 12, k == 5);
      highs += int'(pwm_out);
    end
    n_cmp++; if (highs != 3) begin n_bad++; $display("FAIL busy_highs3 got %0d want 3", highs); end
    step(0, 0, 1'b0);
    n_cmp++; if (duty_ack !== 1'b1) begin n_bad++; $display("FAIL busy_ack12 got %b want 1", duty_ack); end
    highs = int'(pwm_out);
    for (int k = 1; k < M; k++) begin
      step(k, 0, 1'b0);
      highs += int'(pwm_out);
    end
    n_cmp++; if (highs != 12) begin n_bad++; $display("FAIL busy_highs12 got %0d want 12", highs); end
  endtask

  task automatic test_seq_jump();
    int highs;
    run_to(5);
    step(6, 0, 1'b0);
    step(11, 0, 1'b0);
    n_cmp++; if (seq_err !== 1'b1) begin n_bad++; $display("FAIL jump_err got %b want 1", seq_err); end
    n_cmp++; if (pwm_out !== 1'b0) begin n_bad++; $display("FAIL jump_pwm got %b want 0", pwm_out); end
    for (int k = 12; k < M; k++) begin
      step(k, 0, 1'b0);
      n_cmp++; if (seq_err !== 1'b0 || pwm_out !== 1'b0 || period_tick !== 1'b0) begin
        n_bad++; $display("FAIL jump_sync k=%0d got err=%b pwm=%b tick=%b want 0/0/0", k, seq_err, pwm_out, period_tick);
      end
    end
    step(0, 0, 1'b0);
    n_cmp++; if (period_tick !== 1'b1 || pwm_out !== 1'b1) begin n_bad++; $display("FAIL jump_resync got tick=%b pwm=%b want 1/1", period_tick, pwm_out); end
    highs = int'(pwm_out);
    for (int k = 1; k < M; k++) begin
      step(k, 0, 1'b0);
      highs += int'(pwm_out);
    end
    n_cmp++; if (highs != 12) begin n_bad++; $display("FAIL jump_highs got %0d want 12", highs); end
  endtask

  task automatic test_hold();
    int seq[$];
    int ticks = 0;
    int tick_idx = -1;
    step(0, 0, 1'b0);
    for (int v = 1; v <= 7; v++) seq.push_back(v);
    repeat (4) seq.push_back(7);
    for (int v = 8; v < M; v++) seq.push_back(v);
    seq.push_back(0);
    foreach (seq[i]) begin
      step(seq[i], 0, 1'b0);
      if (period_tick) begin ticks++; tick_idx = i; end
      n_cmp++; if (seq_err !== 1'b0) begin n_bad++; $display("FAIL hold_err i=%0d got %b want 0", i, seq_err); end
      n_cmp++; if (pwm_out !== (seq[i] < 12)) begin n_bad++; $display("FAIL hold_pwm i=%0d got %b want %b", i, pwm_out, (seq[i] < 12)); end
    end
    n_cmp++; if (ticks != 1 || tick_idx != 19) begin n_bad++; $display("FAIL hold_period got ticks=%0d idx=%0d want 1/19", ticks, tick_idx); end
  endtask

  task automatic test_reset_mid();
    int highs = 0;
    run_to(2);
    step(3, 10, 1'b1);
    run_to(15);
    step(0, 0, 1'b0);
    n_cmp++; if (duty_ack !== 1'b1) begin n_bad++; $display("FAIL rmid_ack10 got %b want 1", duty_ack); end
    run_to(1);
    step(2, 2, 1'b1);
    step(3, 0, 1'b0);
    n_cmp++; if (pwm_out !== 1'b1 || duty_busy !== 1'b1) begin n_bad++; $display("FAIL rmid_pre got pwm=%b busy=%b want 1/1", pwm_out, duty_busy); end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (pwm_out !== 1'b0 || duty_busy !== 1'b0) begin n_bad++; $display("FAIL rmid_async got pwm=%b busy=%b want 0/0", pwm_out, duty_busy); end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cnt = 5;
    run_to(15);
    for (int k = 0; k < M; k++) begin
      step(k, 0, 1'b0);
      highs += int'(pwm_out);
      n_cmp++; if (duty_ack !== 1'b0) begin n_bad++; $display("FAIL rmid_ack k=%0d got %b want 0", k, duty_ack); end
      n_cmp++; if (period_tick !== (k == 0)) begin n_bad++; $display("FAIL rmid_tick k=%0d got %b want %b", k, period_tick, (k == 0)); end
    end
    n_cmp++; if (highs != 0) begin n_bad++; $display("FAIL rmid_highs got %0d want 0", highs); end
  endtask

  task automatic test_random();
    int c, r;
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 85)      c = (cnt + 1) % M;
      else if (r < 95) c = cnt;
      else             c = int'($urandom_range(0, M - 1));
      step(c, int'($urandom_range(0, M - 1)), ($urandom_range(0, 4) == 0));
      n_cmp++; if (pwm_out !== e_pwm)       begin n_bad++; $display("FAIL rnd_pwm i=%0d got %b want %b", i, pwm_out, e_pwm); end
      n_cmp++; if (duty_busy !== e_busy)    begin n_bad++; $display("FAIL rnd_busy i=%0d got %b want %b", i, duty_busy, e_busy); end
      n_cmp++; if (duty_ack !== e_ack)      begin n_bad++; $display("FAIL rnd_ack i=%0d got %b want %b", i, duty_ack, e_ack); end
      n_cmp++; if (period_tick !== e_tick)  begin n_bad++; $display("FAIL rnd_tick i=%0d got %b want %b", i, period_tick, e_tick); end
      n_cmp++; if (seq_err !== e_err)       begin n_bad++; $display("FAIL rnd_err i=%0d got %b want %b", i, seq_err, e_err); end
    end
  endtask

  initial begin
    test_reset();
    test_duty_zero();
    test_duty_load5();
    test_busy_ignore();
    test_seq_jump();
    test_hold();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
